ifetch_mt: RTL and testbench
============================

# ifetch_mt

Multithreaded instruction-fetch unit for the multicore network processor's pipelined cores. It holds one program counter per hardware thread and picks an enabled thread round-robin each cycle. It drives the synchronous instruction memory address and pairs the returned word with its thread id and return address. Per-thread branch redirects and a global squash keep the fetch stream consistent with the execute stage.

## Interface
- PC_WIDTH, 30, word-address width of each PC
- I_DATAWIDTH, 32, instruction and redirect data width
- NUM_THREADS, 4, hardware threads (2..16)
- TID_WIDTH, 2, thread-id width, equal to clog2(NUM_THREADS)
- RESET_PC, 0, word address loaded into every PC at reset

Ports:
- clk  in  1  core clock
- resetn  in  1  reset, asynchronous, active-low
- en  in  1  pipeline advance; 0 freezes issue and the output stage
- thread_en  in  NUM_THREADS  per-thread run mask
- we  in  1  redirect strobe
- we_tid  in  TID_WIDTH  thread being redirected
- load_data  in  I_DATAWIDTH  byte target; bits [I_DATAWIDTH-1:2] are used
- squashn  in  1  active-low; kills the fetch currently in the output stage
- imem_addr  out  PC_WIDTH  synchronous imem read address (combinational)
- imem_en  out  1  imem clock enable
- instr  in  I_DATAWIDTH  imem read data, one cycle after imem_addr
- out_valid  out  1  instr and the fields below are valid
- out_tid  out  TID_WIDTH  thread of the delivered instruction
- pc_out  out  I_DATAWIDTH  (fetched PC + 1) << 2 of the delivered instruction
- opcode[5:0], rs[4:0], rt[4:0], rd[4:0], sa[4:0], offset[15:0], instr_index[25:0], func[5:0]  out  MIPS fields sliced from instr

## Operation
- State: pc[NUM_THREADS] (PC_WIDTH each), last_tid, and the output stage (out_valid, out_tid, fetched PC).
- Selection: sel_tid is the first enabled thread after last_tid, searching upward modulo NUM_THREADS. issue = en & |thread_en.
- On issue: imem_addr = pc[sel_tid]; pc[sel_tid] <= pc[sel_tid]+1 (wraps modulo 2^PC_WIDTH); last_tid <= sel_tid. imem_en = issue.
- No enabled thread: imem_en=0, last_tid holds, out_valid <= 0 on the next en cycle.
- Redirect (we=1) works whether en is 0 or 1. It sets pc[we_tid] <= load_data[I_DATAWIDTH-1:2].
- Redirect and issue of the same thread in the same cycle: the redirect bypasses the PC register. imem_addr = target and pc <= target+1.
- A redirect also clears out_valid <= 0 if the output stage holds we_tid.
- squashn=0 clears out_valid <= 0 at the next edge. This applies regardless of en. Issue continues normally.
- Output stage, when en=1: out_valid <= issue; out_tid <= sel_tid; pc_out <= {imem_addr+1, 2'b00}.
- Output stage, when en=0: holds its value, except for the squash and redirect clears above.
- A redirect of a disabled thread is legal and takes effect when that thread is re-enabled.

## Timing
- Reset values: every pc = RESET_PC; last_tid = NUM_THREADS-1, so thread 0 issues first; out_valid=0, out_tid=0, pc_out=0. imem_en=0 while resetn=0.
- imem_addr and imem_en are combinational from state and inputs.
- Issue-to-out_valid latency is 1 cycle, matching the 1-cycle imem read. The instr fields are combinational slices of instr.
- Throughput: one fetch per cycle across all threads. With k threads enabled, each thread gets every k-th slot.
- Reset asserted mid-operation discards in-flight fetches immediately (asynchronous clear).

## Structure
- Package ifetch_mt_pkg holds:
  - MIPS field bit positions as constants: opcode 31:26, rs 25:21, rt 20:16, rd 15:11, sa 10:6, func 5:0.
  - The clog2 helper used to check TID_WIDTH.
- Sub-module rr_arbiter (parameter N): inputs req, last_grant; outputs one-hot grant and an encoded index.
- The PC file is a register array held in the top module. Do not build it from RAM, because the same-cycle bypass and increment need register access.

## Test plan
- Reset, thread_en=4'b1111, en=1 for 8 cycles -> imem_addr sequence is 0,0,0,0,1,1,1,1. out_tid is 0,1,2,3,0,1,2,3 starting one cycle later. pc_out for thread 0 is 0x4, then 0x8.
- thread_en=4'b0101 -> alternating tids 0,2. Switch to 4'b0000 -> imem_en=0, and out_valid drops the cycle after.
- we=1, we_tid=2, load_data=0x100 in the cycle thread 2 issues -> imem_addr=0x40 that cycle. Thread 2's next fetch is 0x41.
- Redirect of thread 1 while thread 1 is in the output stage -> out_valid=0 next cycle. squashn=0 -> out_valid=0 next cycle.
- en=0 for 3 cycles with we=1 for thread 3 (target 0x200) -> no issue, and the outputs hold. On resuming, thread 3 fetches 0x80.
- pc[0] preset to 2^30-1 by redirect to 0xFFFFFFFC -> next fetch of thread 0 is 0. resetn pulsed low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/ifetch_mt_pkg.sv
// Shared constants for the multithreaded fetch unit: MIPS field positions and a clog2 helper.
package ifetch_mt_pkg;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SA_MSB     = 10;
  localparam int unsigned SA_LSB     = 6;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;
  localparam int unsigned OFFSET_MSB = 15;
  localparam int unsigned INDEX_MSB  = 25;

  // Ceiling log2, used to validate the thread-id width against the thread count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ifetch_mt_rr_arbiter.sv
// Round-robin pick: first requester strictly after last_grant, searching upward modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Scan N candidates starting one past the previous winner; no request yields grant=0, idx=0.
  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(last_grant) + off) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ifetch_mt.sv
// Multithreaded instruction fetch: per-thread PCs, round-robin issue, one-cycle imem output stage.
module ifetch_mt
  import ifetch_mt_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 30,
  parameter int unsigned I_DATAWIDTH = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   we,
  input  logic [TID_WIDTH-1:0]   we_tid,
  input  logic [I_DATAWIDTH-1:0] load_data,
  input  logic                   squashn,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  input  logic [I_DATAWIDTH-1:0] instr,
  output logic                   out_valid,
  output logic [TID_WIDTH-1:0]   out_tid,
  output logic [I_DATAWIDTH-1:0] pc_out,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             sa,
  output logic [15:0]            offset,
  output logic [25:0]            instr_index,
  output logic [5:0]             func
);

  if (TID_WIDTH != clog2(NUM_THREADS) || NUM_THREADS < 2 || NUM_THREADS > 16) begin : g_bad_params
    $error("ifetch_mt: TID_WIDTH must equal clog2(NUM_THREADS) and NUM_THREADS must be 2..16");
  end

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
  logic [TID_WIDTH-1:0]   last_tid_q, last_tid_d;
  logic                   out_valid_q, out_valid_d;
  logic [TID_WIDTH-1:0]   out_tid_q, out_tid_d;
  logic [I_DATAWIDTH-1:0] pc_out_q, pc_out_d;

  logic [TID_WIDTH-1:0]   sel_tid_c;
  logic [NUM_THREADS-1:0] sel_grant_c;
  logic                   issue_c;
  logic                   bypass_c;
  logic [PC_WIDTH-1:0]    target_c;
  logic [PC_WIDTH-1:0]    next_pc_c;
  logic                   unused_low_bits;

  rr_arbiter #(
    .N  (NUM_THREADS),
    .IW (TID_WIDTH)
  ) u_arb (
    .req        (thread_en),
    .last_grant (last_tid_q),
    .grant      (sel_grant_c),
    .idx        (sel_tid_c)
  );

  // Issue decision, redirect bypass into the fetch address, and the imem strobe.
  assign issue_c         = en & (|thread_en);
  assign target_c        = PC_WIDTH'(load_data[I_DATAWIDTH-1:2]);
  assign bypass_c        = we && (we_tid == sel_tid_c);
  assign imem_addr       = bypass_c ? target_c : pc_q[sel_tid_c];
  assign imem_en         = issue_c & resetn;
  assign next_pc_c       = imem_addr + PC_WIDTH'(1);
  assign unused_low_bits = ^load_data[1:0];

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_pc
    // Per-thread PC next value: redirect loads the target, an issue of this thread advances past the fetch.
    always_comb begin
      pc_d[t] = pc_q[t];
      if (we && (we_tid == TID_WIDTH'(t))) pc_d[t] = target_c;
      if (issue_c && sel_grant_c[t])       pc_d[t] = next_pc_c;
    end

    // Per-thread PC register.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pc_q[t] <= PC_WIDTH'(RESET_PC);
      else         pc_q[t] <= pc_d[t];
    end
  end

  // Round-robin pointer and output stage next state; squash and same-thread redirect kill the stage.
  always_comb begin
    last_tid_d  = last_tid_q;
    out_valid_d = out_valid_q;
    out_tid_d   = out_tid_q;
    pc_out_d    = pc_out_q;
    if (issue_c) last_tid_d = sel_tid_c;
    if (en) begin
      out_valid_d = issue_c;
      out_tid_d   = sel_tid_c;
      pc_out_d    = I_DATAWIDTH'({next_pc_c, 2'b00});
    end
    if (!squashn || (we && (we_tid == out_tid_q))) out_valid_d = 1'b0;
  end

  // Arbiter pointer and output stage registers; reset makes thread 0 the first to issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_tid_q  <= TID_WIDTH'(NUM_THREADS - 1);
      out_valid_q <= 1'b0;
      out_tid_q   <= '0;
      pc_out_q    <= '0;
    end else begin
      last_tid_q  <= last_tid_d;
      out_valid_q <= out_valid_d;
      out_tid_q   <= out_tid_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_tid     = out_tid_q;
  assign pc_out      = pc_out_q;
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs          = instr[RS_MSB:RS_LSB];
  assign rt          = instr[RT_MSB:RT_LSB];
  assign rd          = instr[RD_MSB:RD_LSB];
  assign sa          = instr[SA_MSB:SA_LSB];
  assign func        = instr[FUNC_MSB:FUNC_LSB];
  assign offset      = instr[OFFSET_MSB:0];
  assign instr_index = instr[INDEX_MSB:0];

endmodule

// File: tb/tb_ifetch_mt.sv
// Directed bench for ifetch_mt: stimulus pushes expected fetches, a monitor pops and checks deliveries.
module tb_ifetch_mt;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  thread_en;
  logic        we;
  logic [1:0]  we_tid;
  logic [31:0] load_data;
  logic        squashn;
  logic [29:0] imem_addr;
  logic        imem_en;
  logic [31:0] instr = 32'h0;
  logic        out_valid;
  logic [1:0]  out_tid;
  logic [31:0] pc_out;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [5:0]  func;

  ifetch_mt dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .thread_en   (thread_en),
    .we          (we),
    .we_tid      (we_tid),
    .load_data   (load_data),
    .squashn     (squashn),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_tid     (out_tid),
    .pc_out      (pc_out),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .offset      (offset),
    .instr_index (instr_index),
    .func        (func)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  tid;
    logic [29:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic new_out  = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    return {a[13:0], 2'b10, ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Synchronous instruction memory model.
  always @(posedge clk) if (imem_en) instr <= mem_fn(imem_addr);

  // A delivery is new only when the output stage was loaded (en=1) at the last edge.
  always @(posedge clk) new_out <= en & resetn;

  exp_t        m_e;
  logic [29:0] m_nx;
  logic [31:0] m_w;

  // Monitor: pop the oldest expected fetch for each new delivery and compare all fields.
  always @(negedge clk) begin
    if (resetn && out_valid && new_out) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected delivery: tid %0d pc_out %0h with empty queue", out_tid, pc_out);
      end else begin
        m_e  = q.pop_front();
        m_nx = m_e.addr + 30'd1;
        m_w  = mem_fn(m_e.addr);
        check("out_tid", 64'(out_tid), 64'(m_e.tid));
        check("pc_out", 64'(pc_out), 64'({m_nx, 2'b00}));
        check("opcode/rs/rt/offset", 64'({opcode, rs, rt, offset}), 64'(m_w));
        check("rd/sa/func", 64'({rd, sa, func}), 64'(m_w[15:0]));
        check("instr_index", 64'(instr_index), 64'(m_w[25:0]));
      end
    end
  end

  task automatic cyc(input logic e, input logic [3:0] te, input logic w, input logic [1:0] wt,
                     input logic [31:0] ld, input logic sq, input logic x_ie,
                     input logic [29:0] x_addr, input logic x_v, input logic [1:0] x_tid);
    @(negedge clk);
    en = e; thread_en = te; we = w; we_tid = wt; load_data = ld; squashn = sq;
    #1;
    check("imem_en", 64'(imem_en), 64'(x_ie));
    if (x_ie) check("imem_addr", 64'(imem_addr), 64'(x_addr));
    if (e && x_v) q.push_back('{tid: x_tid, addr: x_addr});
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(x_v));
  endtask

  task automatic run(input logic [3:0] te, input logic [29:0] a, input logic [1:0] tid);
    cyc(1'b1, te, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, a, 1'b1, tid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; en = 1'b1; thread_en = 4'hF; we = 1'b0; we_tid = 2'd0;
    load_data = 32'h0; squashn = 1'b1;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_tid", 64'(out_tid), 64'd0);
    check("reset pc_out", 64'(pc_out), 64'd0);
    check("reset imem_en", 64'(imem_en), 64'd0);
    en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // All four threads: addresses 0,0,0,0,1,1,1,1 with tids 0..3 repeating.
    for (int i = 0; i < 8; i++) run(4'hF, 30'(i / 4), 2'(i % 4));

    // Threads 0 and 2 alternate, then no thread enabled.
    run(4'h5, 30'd2, 2'd0);
    run(4'h5, 30'd2, 2'd2);
    run(4'h5, 30'd3, 2'd0);
    run(4'h5, 30'd3, 2'd2);
    cyc(1'b1, 4'h0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 30'd0, 1'b0, 2'd0);

    // Resume after thread 2; redirect thread 2 to 0x100 in the cycle it issues.
    run(4'hF, 30'd2, 2'd3);
    run(4'hF, 30'd4, 2'd0);
    run(4'hF, 30'd2, 2'd1);
    cyc(1'b1, 4'hF, 1'b1, 2'd2, 32'h100, 1'b1, 1'b1, 30'h40, 1'b1, 2'd2);
    run(4'hF, 30'd3, 2'd3);
    run(4'hF, 30'd5, 2'd0);
    run(4'hF, 30'd3, 2'd1);
    run(4'hF, 30'h41, 2'd2);

    // Redirect thread 1 while it sits in the output stage, then a squash.
    run(4'hF, 30'd4, 2'd3);
    run(4'hF, 30'd6, 2'd0);
    run(4'hF, 30'd4, 2'd1);
    cyc(1'b1, 4'hF, 1'b1, 2'd1, 32'h40, 1'b1, 1'b1, 30'h42, 1'b0, 2'd2);
    run(4'hF, 30'd5, 2'd3);
    run(4'hF, 30'd7, 2'd0);
    run(4'hF, 30'h10, 2'd1);
    cyc(1'b1, 4'hF, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 30'h43, 1'b0, 2'd2);
    run(4'hF, 30'd6, 2'd3);
    run(4'hF, 30'd8, 2'd0);

    // Frozen pipeline with a redirect of thread 3; output stage holds thread 0's fetch.
    repeat (3) cyc(1'b0, 4'hF, 1'b1, 2'd3, 32'h200, 1'b1, 1'b0, 30'd0, 1'b1, 2'd0);
    check("hold out_tid", 64'(out_tid), 64'd0);
    check("hold pc_out", 64'(pc_out), 64'h24);
    run(4'hF, 30'h11, 2'd1);
    run(4'hF, 30'h44, 2'd2);

    // Thread 3 resumes at 0x80 while thread 0 is redirected to the top word address.
    cyc(1'b1, 4'hF, 1'b1, 2'd0, 32'hFFFF_FFFC, 1'b1, 1'b1, 30'h80, 1'b1, 2'd3);
    run(4'hF, 30'h3FFF_FFFF, 2'd0);
    run(4'hF, 30'h12, 2'd1);
    run(4'hF, 30'h45, 2'd2);
    run(4'hF, 30'h81, 2'd3);
    run(4'hF, 30'd0, 2'd0);
    run(4'hF, 30'h13, 2'd1);

    // Asynchronous reset mid-stream drops the in-flight delivery immediately.
    #2;
    resetn = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset imem_en", 64'(imem_en), 64'd0);
    q.delete();
    en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run(4'hF, 30'd0, 2'd0);
    run(4'hF, 30'd0, 2'd1);

    @(negedge clk);
    en = 1'b0;
    #1;
    check("queue drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
